// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : keypad_emulator
// Brief    : Plays accepted key codes as timed presses on a 3x4 scanned keypad.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
    parameter int HOLD_CYCLES = 1024,
    parameter int GAP_CYCLES  = 1024,
    parameter int CW          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] col_drive,
    output logic [3:0] row_sense,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [CW-1:0] C_HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP_LOAD  = CW'(GAP_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    row_oh_q, row_oh_d;
    logic [2:0]    col_oh_q, col_oh_d;
    logic [3:0]    row_sense_q, row_sense_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          dec_valid;
    logic [3:0]    dec_row;
    logic [2:0]    dec_col;

    // Key code to one-hot (row, col) position on the keypad matrix.
    always_comb begin
        dec_valid = 1'b1;
        dec_row   = 4'b0000;
        dec_col   = 3'b000;
        case (key_code)
            4'd1:    begin dec_row = 4'b0001; dec_col = 3'b001; end
            4'd2:    begin dec_row = 4'b0001; dec_col = 3'b010; end
            4'd3:    begin dec_row = 4'b0001; dec_col = 3'b100; end
            4'd4:    begin dec_row = 4'b0010; dec_col = 3'b001; end
            4'd5:    begin dec_row = 4'b0010; dec_col = 3'b010; end
            4'd6:    begin dec_row = 4'b0010; dec_col = 3'b100; end
            4'd7:    begin dec_row = 4'b0100; dec_col = 3'b001; end
            4'd8:    begin dec_row = 4'b0100; dec_col = 3'b010; end
            4'd9:    begin dec_row = 4'b0100; dec_col = 3'b100; end
            4'd10:   begin dec_row = 4'b1000; dec_col = 3'b001; end
            4'd0:    begin dec_row = 4'b1000; dec_col = 3'b010; end
            4'd11:   begin dec_row = 4'b1000; dec_col = 3'b100; end
            default: dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_oh_d    = row_oh_q;
        col_oh_d    = col_oh_q;
        row_sense_d = 4'b0000;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_valid && ready_q) begin
                    if (dec_valid) begin
                        row_oh_d = dec_row;
                        col_oh_d = dec_col;
                        cnt_d    = C_HOLD_LOAD;
                        state_d  = S_PRESS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PRESS: begin
                // Only the latched column matters; other strobes are ignored.
                if (|(col_drive & col_oh_q)) begin
                    row_sense_d = row_oh_q;
                end
                if (cnt_q == '0) begin
                    cnt_d   = C_GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            row_oh_q    <= 4'b0000;
            col_oh_q    <= 3'b000;
            row_sense_q <= 4'b0000;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_oh_q    <= row_oh_d;
            col_oh_q    <= col_oh_d;
            row_sense_q <= row_sense_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign row_sense = row_sense_q;
    assign key_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_emulator
// Brief    : Directed self-checking bench for keypad_emulator (HOLD=4, GAP=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

    localparam int HOLD = 4;
    localparam int GAP  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] col_drive;
    logic [3:0] row_sense;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    int         dig_q[$];

    // Keypad map indexed by key code 0..11: row and column positions.
    int         row_tab[12] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3};
    int         col_tab[12] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 2};
    logic [2:0] rot[3]      = '{3'b001, 3'b010, 3'b100};
    int         seq[4]      = '{1, 2, 3, 4};

    keypad_emulator #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .CW         (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_drive(col_drive),
        .row_sense(row_sense),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] mc;
        logic [3:0] mr;
        int         idx, hs, last_hs, got, zc, dec;
        bit         pressed, hs_now;
        logic [2:0] prev_col;

        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; col_drive = 3'b000;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_row",   32'(row_sense), 32'd0);
        chk("reset_ready", 32'(key_ready), 32'd1);
        chk("reset_busy",  32'(busy),      32'd0);
        chk("reset_done",  32'(done),      32'd0);
        chk("reset_err",   32'(err),       32'd0);

        // Key 8 under a rotating column scan.
        key_valid = 1'b1; key_code = 4'd8;
        step();
        key_valid = 1'b0; key_code = 4'hF;
        chk("k8_busy_start",  32'(busy),      32'd1);
        chk("k8_ready_start", 32'(key_ready), 32'd0);
        for (int j = 1; j <= 10; j++) begin
            col_drive = rot[j % 3];
            exp_q.push_back((j <= HOLD && rot[j % 3] == 3'b010) ? 4'b0100 : 4'b0000);
            step();
            chk("k8_row",  32'(row_sense), 32'(exp_q.pop_front()));
            chk("k8_busy", 32'(busy),      32'(j < HOLD + GAP));
            chk("k8_done", 32'(done),      32'(j == HOLD + GAP));
        end

        // Whole key map: mapped column answers, the other two stay silent.
        for (int k = 0; k < 12; k++) begin
            mc = 3'(1 << col_tab[k]);
            mr = 4'(1 << row_tab[k]);
            key_valid = 1'b1; key_code = 4'(k); col_drive = mc;
            step();
            key_valid = 1'b0;
            for (int j = 1; j <= HOLD; j++) begin
                col_drive = (j == 2) ? {mc[1:0], mc[2]} : (j == 3) ? {mc[0], mc[2:1]} : mc;
                exp_q.push_back((col_drive == mc) ? mr : 4'b0000);
                step();
                chk("map_row", 32'(row_sense), 32'(exp_q.pop_front()));
            end
            wait_done("map_done");
        end

        // Invalid codes 12 and 15, then key 1 on the very next edge.
        col_drive = 3'b111;
        key_valid = 1'b1; key_code = 4'd12;
        step();
        chk("inv12_err",  32'(err),       32'd1);
        chk("inv12_busy", 32'(busy),      32'd0);
        chk("inv12_rdy",  32'(key_ready), 32'd1);
        chk("inv12_row",  32'(row_sense), 32'd0);
        chk("inv12_done", 32'(done),      32'd0);
        key_code = 4'd15;
        step();
        chk("inv15_err",  32'(err),       32'd1);
        chk("inv15_busy", 32'(busy),      32'd0);
        chk("inv15_row",  32'(row_sense), 32'd0);
        chk("inv15_done", 32'(done),      32'd0);
        key_code = 4'd1;
        step();
        key_valid = 1'b0;
        chk("after_inv_err",  32'(err),  32'd0);
        chk("after_inv_busy", 32'(busy), 32'd1);
        wait_done("after_inv_done");

        // Back-to-back keys decoded by a simple scanner model.
        idx = 0; hs = 0; last_hs = 0; got = 0; zc = 3; pressed = 1'b0;
        for (int cyc = 0; cyc < 48; cyc++) begin
            if (idx < 4) begin
                key_valid = 1'b1;
                key_code  = key_ready ? 4'(seq[idx]) : 4'($urandom_range(0, 15));
            end else begin
                key_valid = 1'b0;
            end
            hs_now = key_valid && key_ready;
            if (hs_now) begin
                dig_q.push_back(seq[idx]);
                if (hs > 0) chk("b2b_spacing", 32'(cyc - last_hs), 32'(HOLD + GAP + 1));
                last_hs = cyc;
                hs++;
                idx++;
            end
            col_drive = rot[cyc % 3];
            prev_col  = col_drive;
            step();
            chk("b2b_err", 32'(err), 32'd0);
            if (row_sense != 4'b0000) begin
                zc = 0;
                if (!pressed) begin
                    pressed = 1'b1;
                    got++;
                    dec = -1;
                    for (int i = 0; i < 12; i++)
                        if (4'(1 << row_tab[i]) == row_sense && 3'(1 << col_tab[i]) == prev_col)
                            dec = i;
                    chk("scan_pending", 32'(dig_q.size() > 0), 32'd1);
                    if (dig_q.size() > 0) chk("scan_digit", 32'(dec), 32'(dig_q.pop_front()));
                end
            end else begin
                if (zc < 3) zc++;
                if (zc >= 3) pressed = 1'b0;
            end
        end
        key_valid = 1'b0;
        chk("b2b_handshakes", 32'(hs),           32'd4);
        chk("scan_count",     32'(got),          32'd4);
        chk("scan_leftover",  32'(dig_q.size()), 32'd0);

        // Asynchronous reset in the middle of a key-5 press.
        key_valid = 1'b1; key_code = 4'd5; col_drive = 3'b010;
        step();
        key_valid = 1'b0;
        step(); step();
        chk("rst_pre_row", 32'(row_sense), 32'b0010);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_row", 32'(row_sense), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst_post_ready", 32'(key_ready), 32'd1);
        chk("rst_post_busy",  32'(busy),      32'd0);
        chk("rst_post_row",   32'(row_sense), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable responder for the 3-column × 4-row membrane keypad scan interface. It accepts key codes through a valid/ready handshake and plays each one as a timed key press: it watches the column strobes driven by the keypad scanner and answers on the row-sense lines exactly as a physical keypad would. It lets the keypad-scanner / safe-controller path be exercised on silicon or FPGA without a physical keypad, for example to replay unlock sequences in self-test or bring-up.

## Interface
Parameters:
- HOLD_CYCLES, default 1024: clk cycles a key stays pressed; legal range ≥ 1.
- GAP_CYCLES, default 1024: clk cycles of forced release after each press, before the next key is accepted; legal range ≥ 1.
- CW, default 16: width of the internal duration counter; must satisfy 2^CW > max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- col_drive, input, 3: column strobes from the scanner, active-high; bit c strobes column c.
- row_sense, output, 4: row returns to the scanner, active-high, registered; bit r is row r.
- key_valid, input, 1: a key code is offered.
- key_code, input, 4: key to press. Codes 0–9 are digits, 10 is `*`, 11 is `#`, 12–15 are invalid.
- key_ready, output, 1: the block can accept a key this cycle.
- busy, output, 1: a press or release gap is in progress.
- done, output, 1: one-cycle pulse when a release gap ends.
- err, output, 1: one-cycle pulse when an invalid code is accepted.

## Operation
Key map, given as (row, col):
- 1 → (0,0), 2 → (0,1), 3 → (0,2)
- 4 → (1,0), 5 → (1,1), 6 → (1,2)
- 7 → (2,0), 8 → (2,1), 9 → (2,2)
- `*` → (3,0), 0 → (3,1), `#` → (3,2)

State machine, states IDLE, PRESS, GAP:
- IDLE:
  - key_ready = 1.
  - A handshake occurs when key_valid && key_ready.
  - Valid code: latch (row, col), load counter = HOLD_CYCLES−1, go to PRESS.
  - Invalid code (12–15): pulse err on the next cycle and stay in IDLE. No press occurs and done does not pulse.
- PRESS:
  - Each cycle: row_sense[row] ← col_drive[col]; all other row bits ← 0.
  - The counter decrements each cycle. When it reaches 0, load GAP_CYCLES−1 and go to GAP.
- GAP:
  - row_sense ← 0.
  - The counter decrements each cycle. When it reaches 0, pulse done, go to IDLE.
- busy = 1 in PRESS and GAP. key_ready = 1 only in IDLE. Both are registered state decodes.
- Multiple column strobes set in the same cycle: the pressed row answers if its own column bit is set, regardless of the other bits.
- Only one key is ever pressed at a time; the block never produces a multi-key pattern.
- key_code is ignored whenever key_ready = 0. There is no queueing: the upstream holds key_valid until it sees ready.

## Timing
- Reset values: row_sense = 0, key_ready = 1, busy = 0, done = 0, err = 0, state = IDLE, counter = 0.
- Reset asserted mid-PRESS clears row_sense asynchronously, without waiting for a clk edge.
- Handshake at edge N puts the block in PRESS from N+1. The first row response to col_drive appears at edge N+2 (one-register latency from col_drive to row_sense).
- PRESS lasts exactly HOLD_CYCLES cycles and GAP exactly GAP_CYCLES cycles.
- done is high for the single cycle in which the state returns to IDLE, so key_ready is already 1 in that same cycle.
- A key offered together with done is accepted. Back-to-back keys therefore repeat with a period of HOLD_CYCLES+GAP_CYCLES+1.
- After an err pulse, key_ready stays 1, so a new key can be accepted on the very next edge.
- The counter never wraps: it is only decremented while it is nonzero, and it is reloaded on every state entry.
- row_sense is a pure function of registered state and col_drive sampled one edge earlier. It is glitch-free at the outputs.

## Test plan
- Reset behaviour: assert rst mid-PRESS for key 5 with col_drive = 3'b010. Required: row_sense drops to 0 immediately; key_ready = 1 and busy = 0 after rst deasserts.
- Single key, rotating scan: key 8 with HOLD = 4, GAP = 3, col_drive rotating 001 → 010 → 100. Required:
  - row_sense = 4'b0100 exactly one cycle after each col_drive = 010, and 0 otherwise.
  - busy high for 7 cycles, then one done pulse.
- Full key map: each of the 12 valid codes with col_drive held at the mapped column (one-hot). Required: row_sense equals the one-hot bit of the mapped row; with col_drive held at the other two columns, row_sense stays 0.
- Invalid codes: codes 12 and 15. Required: an err pulse, busy stays 0, row_sense stays 0, no done pulse; a following key 1 is accepted on the next edge.
- Back-to-back handshakes: key_valid held high with the sequence 1, 2, 3, 4. Required: exactly 4 handshakes, spaced HOLD+GAP+1 cycles apart; key_code changes while busy have no effect.
- Integration: drive the sequence 1, 2, 3, 4 into the scanner + safe controller path. Required: the controller's received digits match the sequence in order, with no repeats or dropped digits.
